// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and byte-lane helper for the write-slave memory.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BYTE = 3'd0,
        HALF = 3'd1,
        WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Control captured in the address phase and consumed in the data phase.
    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic [1:0] lane;
    } dphase_t;

    // Little-endian byte strobe for a naturally aligned access.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << lane;
            3'd1:    m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-organised storage with a byte-strobed synchronous write and async read.
module ahb_slave_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        strb,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    // Contents are deliberately not reset.
    logic [3:0][7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[waddr][b] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_write_slave.sv
// AHB-Lite slave memory: address decode, wait-state/error FSM and data-phase control.
module ahb_write_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN    = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_LAST = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    dphase_t          dph_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      hrdata_q;
    logic [31:0]      rdata;

    htrans_e          trans;
    hsize_e           size;
    logic             ready;
    logic             accept;
    logic             addr_err, size_err, align_err, err;
    logic [31:0]      word_off;
    logic             rd_last, wr_last;

    assign trans = htrans_e'(HTRANS);
    assign size  = hsize_e'(HSIZE);

    // Only WAIT and the first ERROR cycle stretch the data phase.
    assign ready  = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign accept = ready && ((trans == NONSEQ) || (trans == SEQ));

    assign word_off  = HADDR - BASE_ADDR;
    assign addr_err  = (HADDR < BASE_ADDR) || (word_off >= SPAN);
    assign size_err  = HSIZE > 3'(WORD);
    assign align_err = ((size == HALF) && HADDR[0]) ||
                       ((size == WORD) && (HADDR[1:0] != 2'b00));
    assign err       = addr_err || size_err || align_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_LAST;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            // IDLE, LAST and ERR2 all present HREADY high and may take a new transfer.
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end else begin
                        state_d = S_LAST;
                    end
                end
            end
        endcase
    end

    assign rd_last = (state_q == S_LAST) && !dph_q.write;
    assign wr_last = (state_q == S_LAST) &&  dph_q.write;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            dph_q    <= '0;
            idx_q    <= '0;
            hrdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                dph_q.write <= HWRITE;
                dph_q.size  <= HSIZE;
                dph_q.lane  <= HADDR[1:0];
                idx_q       <= word_off[IDX_W+1:2];
            end
            if (rd_last) hrdata_q <= rdata;
        end
    end

    ahb_slave_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (IDX_W)
    ) u_mem (
        .clk   (HCLK),
        .we    (wr_last),
        .strb  (lane_mask(dph_q.size, dph_q.lane)),
        .waddr (idx_q),
        .wdata (HWDATA),
        .raddr (idx_q),
        .rdata (rdata)
    );

    assign HREADY = ready;
    assign HRESP  = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA = rd_last ? rdata : hrdata_q;

endmodule

// File: tb/tb_ahb_write_slave.sv
// Scoreboard bench: a zero-wait and a three-wait slave share one master bus, selected by sel.
module tb_ahb_write_slave;

    typedef struct {
        logic        resp;
        logic        chk;
        logic [31:0] data;
        int          waits;
        string       nm;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] hwdata = 32'd0;

    logic [1:0]  htrans0, htrans1;
    logic [31:0] hrdata0, hrdata1, hrdata;
    logic        hready0, hready1, hready;
    logic        hresp0, hresp1, hresp;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_pend = 0;

    always #5 hclk = ~hclk;

    assign htrans0 = sel ? 2'b00 : htrans;
    assign htrans1 = sel ? htrans : 2'b00;
    assign hready  = sel ? hready1 : hready0;
    assign hresp   = sel ? hresp1  : hresp0;
    assign hrdata  = sel ? hrdata1 : hrdata0;

    ahb_write_slave #(.BASE_ADDR(32'h0), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr), .HTRANS(htrans0), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0));

    ahb_write_slave #(.BASE_ADDR(32'h0), .DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
        .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr), .HTRANS(htrans1), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'hC3, b, ~b, 8'h5A};
    endfunction

    // Monitor: a data phase is open from the accepting edge until a cycle with HREADY high.
    initial begin
        exp_t cur;
        int   wc;
        wc = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                mon_pend = 0;
                continue;
            end
            if (mon_pend) begin
                if (!hready) begin
                    wc++;
                    chk({cur.nm, "_resp_wait"}, 32'(hresp), 32'(cur.resp));
                end else begin
                    chk({cur.nm, "_waits"}, 32'(wc), 32'(cur.waits));
                    chk({cur.nm, "_resp"}, 32'(hresp), 32'(cur.resp));
                    if (cur.chk) chk({cur.nm, "_rdata"}, hrdata, cur.data);
                    mon_pend = 0;
                end
            end
            if (hready && htrans[1]) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept got addr %h want no transfer", haddr);
                end else begin
                    cur      = expq.pop_front();
                    mon_pend = 1;
                    wc       = 0;
                end
            end
        end
    end

    // Present an address phase, hold it until accepted, then drive its write data.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic rsp, input logic [31:0] d,
                        input int ws, input string nm);
        exp_t e;
        int   n;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
        e.resp = rsp; e.chk = !w && !rsp; e.data = d; e.waits = ws; e.nm = nm;
        expq.push_back(e);
        n = 0;
        @(negedge hclk);
        while (!hready && n < 64) begin
            @(negedge hclk);
            n++;
        end
        if (!hready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout got hready 0 want 1", nm);
        end
        @(posedge hclk);
        #1;
        htrans = 2'b00;
        hwdata = wd;
    endtask

    task automatic flush();
        int n;
        n = 0;
        while ((mon_pend || expq.size() != 0) && n < 100) begin
            @(posedge hclk);
            n++;
        end
        if (mon_pend || expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout got %0d pending want 0", expq.size());
        end
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge hclk);
        #1;
        chk("rst0_hready", 32'(hready), 32'd1);
        chk("rst0_hresp", 32'(hresp), 32'd0);
        chk("rst0_hrdata", hrdata, 32'd0);
        sel = 1'b1;
        #1;
        chk("rst3_hready", 32'(hready), 32'd1);
        chk("rst3_hresp", 32'(hresp), 32'd0);
        sel = 1'b0;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Zero-wait slave: back-to-back writes then reads.
        xfer(32'h0, 1, 3'd2, 32'hDEADBEEF, 0, 32'h0, 0, "wr_w0");
        xfer(32'h4, 1, 3'd2, 32'h12345678, 0, 32'h0, 0, "wr_w1");
        xfer(32'h0, 0, 3'd2, 32'h0, 0, 32'hDEADBEEF, 0, "rd_w0");
        xfer(32'h4, 0, 3'd2, 32'h0, 0, 32'h12345678, 0, "rd_w1");

        // Sub-word lane merges.
        xfer(32'h0, 1, 3'd2, 32'h11223344, 0, 32'h0, 0, "wr_base");
        xfer(32'h2, 1, 3'd0, 32'h00AA0000, 0, 32'h0, 0, "wr_byte2");
        xfer(32'h0, 0, 3'd2, 32'h0, 0, 32'h11AA3344, 0, "rd_byte2");
        xfer(32'h0, 1, 3'd1, 32'h0000BEEF, 0, 32'h0, 0, "wr_half0");
        xfer(32'h0, 0, 3'd2, 32'h0, 0, 32'h11AABEEF, 0, "rd_half0");

        // Errors; the following read is issued while the slave sits in ERR2.
        xfer(32'h2, 1, 3'd2, 32'hFFFFFFFF, 1, 32'h0, 1, "err_misalign");
        xfer(32'h0, 1, 3'd3, 32'hFFFFFFFF, 1, 32'h0, 1, "err_size3");
        xfer(32'h0, 0, 3'd2, 32'h0, 0, 32'h11AABEEF, 0, "rd_after_err");
        flush();

        // Out-of-range write must leave every word intact.
        for (int i = 0; i < 256; i++) xfer(32'(i * 4), 1, 3'd2, pat(i), 0, 32'h0, 0, "fill");
        xfer(32'h400, 1, 3'd2, 32'hFFFFFFFF, 1, 32'h0, 1, "err_range");
        for (int i = 0; i < 256; i++) xfer(32'(i * 4), 0, 3'd2, 32'h0, 0, pat(i), 0, "readback");
        flush();

        // Three-wait slave.
        sel = 1'b1;
        #1;
        xfer(32'h8, 1, 3'd2, 32'h13579BDF, 0, 32'h0, 3, "ws_wr8");
        xfer(32'h8, 0, 3'd2, 32'h0, 0, 32'h13579BDF, 3, "ws_rd8");
        xfer(32'hC, 1, 3'd2, 32'hCAFEF00D, 0, 32'h0, 3, "ws_wrC");
        xfer(32'h400, 1, 3'd2, 32'h0, 1, 32'h0, 1, "ws_err_range");
        flush();

        // Reset during the first WAIT cycle of a write.
        xfer(32'hC, 1, 3'd2, 32'h55555555, 0, 32'h0, 3, "ws_wr_abort");
        @(negedge hclk);
        #2;
        hresetn = 1'b0;
        #1;
        chk("midrst_hready", 32'(hready), 32'd1);
        chk("midrst_hresp", 32'(hresp), 32'd0);
        chk("midrst_hrdata", hrdata, 32'd0);
        repeat (2) @(negedge hclk);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        xfer(32'hC, 0, 3'd2, 32'h0, 0, 32'hCAFEF00D, 3, "ws_rdC");
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_write_slave.md
Name: ahb_write_slave

Overview:
- AHB-Lite slave memory: the downstream stage that consumes the master-driven signal group HADDR/HTRANS/HWRITE/HSIZE/HWDATA.
- Returns HREADY/HRESP/HRDATA to the master.
- Word-organised register-file memory with little-endian byte-lane writes.
- Configurable wait states and a two-cycle ERROR response for bad accesses.
- Serves as the DUT behind the AHB write bench.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- DEPTH_WORDS, 256: number of 32-bit words; power of two, range 4..4096.
- WAIT_STATES, 0: HREADY-low cycles inserted per OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  clock, all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  address-phase byte address.
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  0 byte, 1 halfword, 2 word; values above 2 are illegal.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data, valid when HREADY=1 and HRESP=0 in a read data phase.
- HREADY  out  1  low extends the current data phase.
- HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (async assert, sync release): HREADY=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Transfer acceptance: a transfer is accepted on a rising edge with HREADY=1 and HTRANS[1]=1.
  - On acceptance, latch addr, write, size and err.
  - Transfers with HTRANS IDLE/BUSY get a zero-wait OKAY data phase with no side effect.
- err=1 when any of these holds:
  - addr < BASE_ADDR, or addr >= BASE_ADDR + 4*DEPTH_WORDS.
  - HSIZE > 2.
  - Misalignment: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: no data phase pending. HREADY=1, HRESP=0. On an accepted transfer:
    - err=1 goes to ERR1.
    - else WAIT_STATES>0 goes to WAIT, with counter=WAIT_STATES-1.
    - else goes to LAST.
  - WAIT: HREADY=0, HRESP=0. Counter decrements; goes to LAST when counter==0.
  - LAST: HREADY=1, HRESP=0. The transfer completes this cycle.
    - Write: on this edge, update the byte lanes of mem[(addr-BASE_ADDR)>>2] selected by size and addr[1:0] from the same lanes of HWDATA. Other lanes keep their value.
    - Read: HRDATA is driven combinationally from the full 32-bit word.
    - A pipelined transfer accepted on this edge follows the same rules as in IDLE. Otherwise go to IDLE.
  - ERR1: HREADY=0, HRESP=1, no memory access. Next state is ERR2.
  - ERR2: HREADY=1, HRESP=1. A transfer accepted here is processed as in IDLE. The master is expected to drive IDLE here; if it does not, the slave still honours the transfer.
- HRDATA outside a read LAST cycle holds its last registered value. Bench checks HRDATA only in read LAST cycles.
- Address and control inputs are ignored while HREADY=0. HWDATA is sampled only on the edge that ends a write LAST cycle.
- Latency:
  - OKAY transfer: data phase of WAIT_STATES+1 cycles.
  - ERROR transfer: always 2 cycles, regardless of WAIT_STATES.
- Read after write to the same word is back-to-back: the read's LAST comes after the write's LAST edge, so it returns the new data with no forwarding.
- Reset mid-transfer: the pending access is dropped, the memory word is not written, and outputs return to their reset values immediately.

Decomposition:
- Package ahb_pkg:
  - htrans_e enum: IDLE, BUSY, NONSEQ, SEQ.
  - hsize_e enum: BYTE, HALF, WORD.
  - HRESP_OKAY and HRESP_ERROR constants.
  - Function lane_mask(size, addr[1:0]) returning a 4-bit strobe.
- Sub-module ahb_slave_mem: DEPTH_WORDS x 32 array with byte-strobed write port and async read port.
- FSM, decode and counter stay in the top module.

Test Plan:
- Reset, WAIT_STATES=0, word writes 0xDEADBEEF@0x0 and 0x12345678@0x4 back-to-back, then reads -> both writes single-cycle OKAY; reads return the same values in consecutive cycles.
- Byte write 0xAA to 0x2 (HWDATA=0x00AA0000) over word 0x11223344 -> read 0x11AA3344. Halfword 0xBEEF to 0x0 -> read 0x11AABEEF.
- WAIT_STATES=3, write then read 0x8 -> HREADY low exactly 3 cycles per data phase; next address held and not sampled until HREADY=1.
- Word write to 0x400 with DEPTH_WORDS=256 -> cycle1 HREADY=0/HRESP=1, cycle2 HREADY=1/HRESP=1; memory unchanged, verified by a full readback.
- Misaligned word write at 0x2 and HSIZE=3 write at 0x0 -> both give ERROR, no write. Transfer issued during ERR2 -> accepted normally.
- HRESETn asserted during a WAIT cycle of a write 0x55555555@0xC -> outputs at reset values at once; later read of 0xC returns the prior contents.
